// File: rtl/aes_serial_block_collector.sv
// Assembles the AES core's byte-serial output into 128-bit blocks and offers
// each completed block downstream through a single holding register with valid/ready.
//
// state     | meaning
// S_COLLECT | accepting bytes into the assembly register
// S_FULL    | assembly holds a complete block waiting for the holding register
module aes_serial_block_collector #(
  parameter int BYTES  = 16,
  parameter int BYTE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_W-1:0]       byte_in,
  input  logic                    byte_valid,
  input  logic                    block_start,
  output logic [BYTES*BYTE_W-1:0] block_out,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clr_err
);

  localparam int BLK_W = BYTES * BYTE_W;
  localparam int CW    = $clog2(BYTES);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_FULL    = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_asm;
  logic [BLK_W-1:0] r_hold;
  logic             r_hold_valid;
  logic             r_busy;
  logic             r_overflow;
  logic             r_frame_err;

  logic             w_hold_free;
  logic             w_wr;
  logic [CW-1:0]    w_slot;
  logic [CW-1:0]    w_rev;
  logic             w_last;
  logic             w_load;
  logic [BLK_W-1:0] w_load_data;
  logic [BLK_W-1:0] w_done_blk;
  logic [0:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_ovf_set;
  logic             w_ferr_set;

  always_comb begin
    w_hold_free = !r_hold_valid || block_ready;
    w_wr        = (r_state == S_COLLECT) && byte_valid;
    w_slot      = block_start ? '0 : r_cnt;
    // slot k lives at the k-th byte counted from the MSB end
    w_rev       = ~w_slot;
    w_last      = w_wr && (w_slot == CW'(BYTES - 1));
    w_done_blk  = {r_asm[BLK_W-1:BYTE_W], byte_in};
    w_ovf_set   = (r_state == S_FULL) && byte_valid;
    w_ferr_set  = w_wr && block_start && (r_cnt != '0);

    w_load      = 1'b0;
    w_load_data = r_asm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    if (r_state == S_COLLECT) begin
      if (w_wr) begin
        w_cnt_nxt = w_slot + 1'b1;
      end
      if (w_last) begin
        if (w_hold_free) begin
          w_load      = 1'b1;
          w_load_data = w_done_blk;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
    end else if (w_hold_free) begin
      w_load      = 1'b1;
      w_load_data = r_asm;
      w_state_nxt = S_COLLECT;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_COLLECT;
      r_cnt        <= '0;
      r_asm        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_cnt_nxt != '0) || (w_state_nxt == S_FULL);

      if (w_wr) begin
        r_asm[w_rev*BYTE_W +: BYTE_W] <= byte_in;
      end

      // a new load wins over the handshake that empties the hold
      if (w_load) begin
        r_hold       <= w_load_data;
        r_hold_valid <= 1'b1;
      end else if (block_ready) begin
        r_hold_valid <= 1'b0;
      end

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end

      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign block_out   = r_hold;
  assign block_valid = r_hold_valid;
  assign busy        = r_busy;
  assign overflow    = r_overflow;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_aes_serial_block_collector.sv
// Directed bench for the byte-serial block collector: streaming, back-to-back
// blocks, FULL/overflow, framing errors, reset mid-block and clear priority.
module tb_aes_serial_block_collector;

  logic         clk;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         block_start;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         busy;
  logic         overflow;
  logic         frame_err;
  logic         clr_err;

  int n_cmp;
  int n_bad;

  aes_serial_block_collector dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .block_start (block_start),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .busy        (busy),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    byte_in     = b;
    byte_valid  = 1'b1;
    block_start = st;
    step();
    byte_valid  = 1'b0;
    block_start = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b0;
    byte_in     = '0;
    byte_valid  = 1'b0;
    block_start = 1'b0;
    block_ready = 1'b1;
    clr_err     = 1'b0;

    // reset state
    step();
    step();
    chk("rst_out",   block_out,   128'h0);
    chk("rst_valid", block_valid, 128'h0);
    chk("rst_busy",  busy,        128'h0);
    chk("rst_ovf",   overflow,    128'h0);
    chk("rst_ferr",  frame_err,   128'h0);
    rst = 1'b1;

    // single block 00..0F
    send(8'h00, 1'b1);
    chk("t1_busy_mid", busy, 128'h1);
    for (int i = 1; i < 16; i++) send(8'(i), 1'b0);
    chk("t1_valid", block_valid, 128'h1);
    chk("t1_out",   block_out,   128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_busy",  busy,        128'h0);
    step();
    chk("t1_taken", block_valid, 128'h0);

    // two back-to-back blocks
    for (int i = 0; i < 32; i++) begin
      send(8'(i), (i % 16) == 0);
      if (i == 15) begin
        chk("t2_v0",  block_valid, 128'h1);
        chk("t2_b0",  block_out,   128'h000102030405060708090A0B0C0D0E0F);
      end
      if (i == 16) chk("t2_pulse0", block_valid, 128'h0);
      if (i == 31) begin
        chk("t2_v1",  block_valid, 128'h1);
        chk("t2_b1",  block_out,   128'h101112131415161718191A1B1C1D1E1F);
      end
    end
    step();
    chk("t2_pulse1", block_valid, 128'h0);
    chk("t2_ovf",    overflow,    128'h0);
    chk("t2_ferr",   frame_err,   128'h0);

    // hold first block, fill a second, overflow with extra bytes
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), i == 0);
    chk("t3_held", block_valid, 128'h1);
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), i == 0);
    chk("t3_full_busy", busy,      128'h1);
    chk("t3_ovf0",      overflow,  128'h0);
    chk("t3_out_old",   block_out, 128'h000102030405060708090A0B0C0D0E0F);
    send(8'h40, 1'b0);
    chk("t3_ovf1", overflow, 128'h1);
    clr_err = 1'b1;
    send(8'h41, 1'b0);
    clr_err = 1'b0;
    chk("t3_clr_vs_set", overflow, 128'h1);
    send(8'h42, 1'b1);
    chk("t3_out_stable", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t3_ferr_none",  frame_err, 128'h0);
    block_ready = 1'b1;
    step();
    block_ready = 1'b0;
    chk("t3_rel_valid", block_valid, 128'h1);
    chk("t3_rel_out",   block_out,   128'h202122232425262728292A2B2C2D2E2F);
    chk("t3_rel_busy",  busy,        128'h0);
    step();
    chk("t3_hold_out",  block_out,   128'h202122232425262728292A2B2C2D2E2F);
    chk("t3_hold_v",    block_valid, 128'h1);
    block_ready = 1'b1;
    step();
    chk("t3_drained", block_valid, 128'h0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_ovf_clr", overflow, 128'h0);

    // framing error: partial block restarted
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), i == 0);
    chk("t4_ferr0", frame_err, 128'h0);
    send(8'hAA, 1'b1);
    chk("t4_ferr1", frame_err, 128'h1);
    for (int i = 1; i < 16; i++) send(8'(8'hB0 + i), 1'b0);
    chk("t4_valid", block_valid, 128'h1);
    chk("t4_b0",    {120'h0, block_out[127:120]}, 128'hAA);
    chk("t4_out",   block_out, 128'hAAB1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_ferr_clr", frame_err, 128'h0);

    // reset mid-block with a block held
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i), i == 0);
    for (int i = 0; i < 8; i++) send(8'(8'h70 + i), i == 0);
    chk("t5_pre_busy", busy, 128'h1);
    send(8'hEE, 1'b0);
    rst = 1'b0;
    step();
    chk("t5_out",   block_out,   128'h0);
    chk("t5_valid", block_valid, 128'h0);
    chk("t5_busy",  busy,        128'h0);
    chk("t5_ovf",   overflow,    128'h0);
    chk("t5_ferr",  frame_err,   128'h0);
    rst = 1'b1;
    block_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), i == 0);
    chk("t5_new_valid", block_valid, 128'h1);
    chk("t5_new_out",   block_out,   128'h808182838485868788898A8B8C8D8E8F);
    chk("t5_new_ferr",  frame_err,   128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
